// File: rtl/uart_tx_fifo_if.sv
// Write-side bus of uart_tx_fifo: push strobe/data plus FIFO status flags.
`timescale 1ns/1ps

interface uart_tx_fifo_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic       overflow;

    modport master (output wr_en, output wr_data, input full, input empty, input overflow);
    modport slave  (input wr_en, input wr_data, output full, output empty, output overflow);
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter timed by a 16x oversample strobe.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
`timescale 1ns/1ps

module uart_tx_fifo #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           s_tick,
    uart_tx_fifo_if.slave  wr,
    output logic           tx,
    output logic           transmit_active,
    output logic           transmit_over
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt_c;
    logic          push_c;
    logic          pop_c;

    state_t        state;
    logic [TW-1:0] tick;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
`ifdef UART_TX_PARITY_EN
    logic          parity_bit;
`endif

    // A push while full is dropped even if the transmitter pops in the same cycle.
    assign push_c = wr.wr_en && !wr.full;
    assign pop_c  = (state == IDLE) && !wr.empty;

    always_comb begin
        count_nxt_c = count + CW'(push_c) - CW'(pop_c);
    end

    // Storage array carries no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= wr.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            wr.full     <= 1'b0;
            wr.empty    <= 1'b1;
            wr.overflow <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count    <= count_nxt_c;
            wr.full  <= (count_nxt_c == CW'(DEPTH));
            wr.empty <= (count_nxt_c == '0);
            if (wr.wr_en && wr.full) begin
                wr.overflow <= 1'b1;
            end
        end
    end

    // Transmit FSM; tx is registered so reset forces the line idle without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            tick            <= '0;
            bit_idx         <= '0;
            shift_reg       <= '0;
            tx              <= 1'b1;
            transmit_active <= 1'b0;
            transmit_over   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit      <= 1'b0;
`endif
        end else begin
            transmit_over <= 1'b0;
            case (state)
                IDLE: begin
                    if (!wr.empty) begin
                        shift_reg       <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                        parity_bit      <= ^mem[rd_ptr];
`endif
                        tick            <= '0;
                        bit_idx         <= '0;
                        tx              <= 1'b0;
                        transmit_active <= 1'b1;
                        state           <= START;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (tick == TW'(15)) begin
                            tick    <= '0;
                            bit_idx <= '0;
                            tx      <= shift_reg[0];
                            state   <= DATA;
                        end else begin
                            tick <= tick + TW'(1);
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (tick == TW'(15)) begin
                            tick      <= '0;
                            shift_reg <= shift_reg >> 1;
                            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                                tx    <= parity_bit;
                                state <= PARITY;
`else
                                tx    <= 1'b1;
                                state <= STOP;
`endif
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                                tx      <= shift_reg[1];
                            end
                        end else begin
                            tick <= tick + TW'(1);
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (s_tick) begin
                        if (tick == TW'(15)) begin
                            tick  <= '0;
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            tick <= tick + TW'(1);
                        end
                    end
                end
`endif
                STOP: begin
                    if (s_tick) begin
                        if (tick == TW'(SB_TICK - 1)) begin
                            tick            <= '0;
                            transmit_over   <= 1'b1;
                            transmit_active <= 1'b0;
                            state           <= IDLE;
                        end else begin
                            tick <= tick + TW'(1);
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, directed corner cases, random bursts.
`timescale 1ns/1ps

module tb_uart_tx_fifo;

    localparam int unsigned DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned FB = 11;
`else
    localparam int unsigned FB = 10;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_tick = 1'b0;
    logic tx;
    logic transmit_active;
    logic transmit_over;
    bit   tick_rand = 1'b0;

    int passed = 0;
    int total  = 0;

    uart_tx_fifo_if bus ();

    uart_tx_fifo #(.DEPTH(DEPTH), .SB_TICK(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_tick          (s_tick),
        .wr              (bus),
        .tx              (tx),
        .transmit_active (transmit_active),
        .transmit_over   (transmit_over)
    );

    always #5 clk = ~clk;

    // Oversample strobe: every 4th clk, or a random 1-in-3 pattern.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_rand) begin
                s_tick = ($urandom_range(2, 0) == 0);
            end else begin
                s_tick = (ph == 3);
                ph = (ph + 1) % 4;
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame_np;
        logic [10:0] frame_p;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Reference frame: slot 0 is start, slots 1..8 data LSB first, then parity and stop.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {2'b01, d, 1'b0};
`endif
    endfunction

    task automatic push(input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    // Sample one frame mid-bit by counting s_tick, then wait for the end-of-frame pulse.
    task automatic capture(output logic [10:0] bits, output int dur, output int wn,
                           output int bitlen, input bit push_on_over, input logic [7:0] pdata);
        int   ticks;
        int   guard;
        int   t1;
        int   ntr;
        logic prev;
        bits = '0; dur = 0; wn = 0; bitlen = -1; t1 = 0; ntr = 0;
        while (tx !== 1'b0 && wn < 4000) begin
            @(negedge clk);
            wn++;
        end
        if (tx !== 1'b0) begin
            check("frame_start_timeout", 32'(tx), 32'(0));
            return;
        end
        prev  = 1'b0;
        ticks = 0;
        for (int slot = 0; slot < int'(FB); slot++) begin
            guard = 0;
            while (ticks < 8 + 16 * slot && guard < 400) begin
                @(negedge clk);
                dur++;
                guard++;
                if (s_tick) ticks++;
                if (tx !== prev) begin
                    ntr++;
                    if (ntr == 1) t1 = dur;
                    if (ntr == 2) bitlen = dur - t1;
                    prev = tx;
                end
            end
            bits[slot] = tx;
        end
        guard = 0;
        while (transmit_over !== 1'b1 && guard < 400) begin
            @(negedge clk);
            dur++;
            guard++;
        end
        check("over_pulse", 32'(transmit_over), 32'(1));
        check("active_drop", 32'(transmit_active), 32'(0));
        if (push_on_over) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = pdata;
        end
        @(negedge clk);
        if (push_on_over) bus.wr_en = 1'b0;
        check("over_width", 32'(transmit_over), 32'(0));
    endtask

    initial begin
        logic [10:0] bits;
        logic [10:0] exp;
        int          dur;
        int          wn;
        int          bl;
        int          ticks;
        int          guard;
        int          n_over;
        int          n_low;
        logic [7:0]  q [$];

        tbl[0] = '{8'h55, 11'h2AA, 11'h4AA};
        tbl[1] = '{8'hA3, 11'h346, 11'h546};
        tbl[2] = '{8'h0F, 11'h21E, 11'h41E};
        tbl[3] = '{8'hFF, 11'h3FE, 11'h5FE};
        tbl[4] = '{8'h07, 11'h20E, 11'h60E};
        tbl[5] = '{8'h03, 11'h206, 11'h406};
        tbl[6] = '{8'h00, 11'h200, 11'h400};
        tbl[7] = '{8'h80, 11'h300, 11'h700};

        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'(1));
        check("rst_empty", 32'(bus.empty), 32'(1));
        check("rst_full", 32'(bus.full), 32'(0));
        check("rst_overflow", 32'(bus.overflow), 32'(0));
        check("rst_active", 32'(transmit_active), 32'(0));
        check("rst_over", 32'(transmit_over), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Vector table: single frames with fixed 4-clk tick spacing.
        for (int i = 0; i < 8; i++) begin
            push(tbl[i].data);
            capture(bits, dur, wn, bl, 1'b0, 8'h00);
`ifdef UART_TX_PARITY_EN
            exp = tbl[i].frame_p;
`else
            exp = tbl[i].frame_np;
`endif
            check($sformatf("frame_%02h", tbl[i].data), 32'(bits), 32'(exp));
            if (i == 0) begin
                check("bit_len_64clk", 32'(bl), 32'(64));
                check("frame_len", 32'(dur >= int'(FB) * 64 - 3 && dur <= int'(FB) * 64), 32'(1));
            end
            check("empty_after_frame", 32'(bus.empty), 32'(1));
        end

        // Three consecutive pushes: back-to-back frames with a single idle clk.
        q = '{8'hA3, 8'h0F, 8'hFF};
        n_over = 0;
        fork
            begin
                foreach (q[k]) push(q[k]);
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    capture(bits, dur, wn, bl, 1'b0, 8'h00);
                    check($sformatf("b2b_frame%0d", k), 32'(bits), 32'(frame_of(q[k])));
                    if (k > 0) check($sformatf("b2b_gap%0d", k), 32'(wn), 32'(0));
                    n_over++;
                end
            end
        join
        check("b2b_over_count", 32'(n_over), 32'(3));

        // Push coinciding with pop at occupancy 3, write pointer wrapping past DEPTH-1.
        q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h6B};
        fork
            begin
                for (int k = 0; k < 4; k++) push(q[k]);
                check("occ_before", 32'(dut.count), 32'(3));
            end
            begin
                capture(bits, dur, wn, bl, 1'b1, q[4]);
                check("pp_frame0", 32'(bits), 32'(frame_of(q[0])));
                check("occ_pushpop1", 32'(dut.count), 32'(3));
                capture(bits, dur, wn, bl, 1'b1, q[5]);
                check("pp_frame1", 32'(bits), 32'(frame_of(q[1])));
                check("occ_pushpop2", 32'(dut.count), 32'(3));
                for (int k = 2; k < 6; k++) begin
                    capture(bits, dur, wn, bl, 1'b0, 8'h00);
                    check($sformatf("pp_frame%0d", k), 32'(bits), 32'(frame_of(q[k])));
                end
            end
        join
        check("pp_empty", 32'(bus.empty), 32'(1));

        // Overflow while the transmitter is busy: 1 sending + 8 stored + 2 dropped.
        q = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6, 8'hE7, 8'hE8};
        fork
            begin
                push(q[0]);
                repeat (3) @(negedge clk);
                for (int k = 1; k <= 8; k++) begin
                    push(q[k]);
                    if (k == 7) check("full_at_7", 32'(bus.full), 32'(0));
                    if (k == 8) begin
                        check("full_at_8", 32'(bus.full), 32'(1));
                        check("no_ovf_at_8", 32'(bus.overflow), 32'(0));
                    end
                end
                push(8'hF1);
                push(8'hF2);
                check("ovf_set", 32'(bus.overflow), 32'(1));
                check("full_held", 32'(bus.full), 32'(1));
            end
            begin
                for (int k = 0; k < 9; k++) begin
                    capture(bits, dur, wn, bl, 1'b0, 8'h00);
                    check($sformatf("ovf_frame%0d", k), 32'(bits), 32'(frame_of(q[k])));
                end
            end
        join
        repeat (4) @(negedge clk);
        check("ovf_drained_empty", 32'(bus.empty), 32'(1));
        check("ovf_drained_full", 32'(bus.full), 32'(0));
        check("ovf_sticky", 32'(bus.overflow), 32'(1));

        // Random bursts (never more than DEPTH bytes) with irregular s_tick spacing.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ovf_cleared", 32'(bus.overflow), 32'(0));
        tick_rand = 1'b1;
        for (int r = 0; r < 4; r++) begin
            int n;
            logic [7:0] sent [$];
            n = int'($urandom_range(DEPTH, 1));
            sent = {};
            fork
                begin
                    for (int k = 0; k < n; k++) begin
                        logic [7:0] d;
                        d = 8'($urandom);
                        sent.push_back(d);
                        push(d);
                        repeat ($urandom_range(2, 0)) @(negedge clk);
                    end
                end
                begin
                    for (int k = 0; k < n; k++) begin
                        capture(bits, dur, wn, bl, 1'b0, 8'h00);
                        check($sformatf("rnd%0d_frame%0d", r, k), 32'(bits),
                              32'(frame_of(sent.size() > 0 ? sent.pop_front() : 8'h00)));
                    end
                end
            join
            check($sformatf("rnd%0d_ovf", r), 32'(bus.overflow), 32'(0));
            check($sformatf("rnd%0d_empty", r), 32'(bus.empty), 32'(1));
        end
        tick_rand = 1'b0;
        repeat (4) @(negedge clk);

        // Reset during data bit 3 of 0xC4 with two bytes still queued.
        push(8'hC4);
        push(8'hAA);
        push(8'hBB);
        guard = 0;
        while (tx !== 1'b0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        ticks = 0;
        guard = 0;
        while (ticks < 8 + 16 * 4 && guard < 1000) begin
            @(negedge clk);
            guard++;
            if (s_tick) ticks++;
        end
        check("mid_bit3_tx", 32'(tx), 32'(0));
        check("mid_bit3_empty", 32'(bus.empty), 32'(0));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tx", 32'(tx), 32'(1));
        check("async_rst_empty", 32'(bus.empty), 32'(1));
        check("async_rst_active", 32'(transmit_active), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        n_over = 0;
        n_low  = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (transmit_over) n_over++;
            if (!tx) n_low++;
        end
        check("post_rst_no_over", 32'(n_over), 32'(0));
        check("post_rst_tx_idle", 32'(n_low), 32'(0));
        check("post_rst_empty", 32'(bus.empty), 32'(1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
